// File: rtl/lot_pkg.sv
// Shared types and constants for the lottery ticket transmitter.
package lot_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StDigit,
        StGap,
        StFim,
        StCap,
        StEnd,
        StAbort
    } state_e;

    localparam int unsigned NUM_DIGITS = 5;
    localparam int unsigned BCD_MAX    = 9;

    localparam logic [1:0] PRM_NONE = 2'b00;
    localparam logic [1:0] PRM_1    = 2'b01;
    localparam logic [1:0] PRM_2    = 2'b10;

    // Digit 0 is the most significant nibble, sent first.
    function automatic logic [3:0] digit_at(logic [19:0] t, logic [2:0] i);
        logic [19:0] sh;
        sh = t >> (4 * (NUM_DIGITS - 1 - 32'(i)));
        return sh[3:0];
    endfunction

endpackage

// File: rtl/lot_ticket_tx_if.sv
// Handshake and checker-side signals of the lottery ticket transmitter.
interface lot_ticket_tx_if;
    logic        start;
    logic [19:0] ticket;
    logic [1:0]  premio_in;
    logic        ready;
    logic [3:0]  num;
    logic        insere;
    logic        fim;
    logic        fim_jogo;
    logic        done;
    logic        err;
    logic [1:0]  result;
    logic [7:0]  games;

    modport master (
        output start, ticket, premio_in,
        input  ready, num, insere, fim, fim_jogo, done, err, result, games
    );

    modport slave (
        input  start, ticket, premio_in,
        output ready, num, insere, fim, fim_jogo, done, err, result, games
    );
endinterface

// File: rtl/lot_bcd_check.sv
// Flags a 5-digit ticket that contains any nibble above the BCD range.
module lot_bcd_check
    import lot_pkg::*;
(
    input  logic [19:0] ticket_i,
    output logic        invalid_o
);
    always_comb begin
        invalid_o = 1'b0;
        for (int k = 0; k < int'(NUM_DIGITS); k++) begin
            if (32'(ticket_i[4*k +: 4]) > BCD_MAX) begin
                invalid_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/lot_ticket_tx.sv
// Sends a latched 5-digit BCD ticket to the checker and records the prize.
// Optional LOT_TX_GAP_EN inserts an idle cycle after each of the first four digits.
module lot_ticket_tx
    import lot_pkg::*;
(
    input logic            clk,
    input logic            reset,
    lot_ticket_tx_if.slave bus
);
    state_e      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [19:0] ticket_q, ticket_d;
    logic        err_q, err_d;
    logic [1:0]  result_q, result_d;
    logic [7:0]  games_q, games_d;
    logic        accept, invalid;
    logic        ready, insere, fim, fim_jogo, done;
    logic [3:0]  num;

    assign accept   = (state_q == StIdle) && bus.start;
    assign ticket_d = accept ? bus.ticket : ticket_q;

    // Checks the value being latched so the abort decision is made in the accept cycle.
    lot_bcd_check u_bcd_check (
        .ticket_i  (ticket_d),
        .invalid_o (invalid)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        err_d    = err_q;
        result_d = result_q;
        games_d  = games_q;
        ready    = 1'b0;
        num      = 4'd0;
        insere   = 1'b0;
        fim      = 1'b0;
        fim_jogo = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            StIdle: begin
                ready = 1'b1;
                if (accept) begin
                    idx_d   = 3'd0;
                    err_d   = invalid;
                    state_d = invalid ? StAbort : StDigit;
                end
            end
            StDigit: begin
                num    = digit_at(ticket_q, idx_q);
                insere = 1'b1;
                idx_d  = idx_q + 3'd1;
                if (idx_q == 3'(NUM_DIGITS - 1)) begin
                    state_d = StFim;
                end else begin
`ifdef LOT_TX_GAP_EN
                    state_d = StGap;
`else
                    state_d = StDigit;
`endif
                end
            end
            StGap: begin
                // Index already advanced; keep showing the digit just sent.
                num     = digit_at(ticket_q, 3'(idx_q - 3'd1));
                state_d = StDigit;
            end
            StFim: begin
                fim     = 1'b1;
                state_d = StCap;
            end
            StCap: begin
                result_d = (bus.premio_in == PRM_1 || bus.premio_in == PRM_2) ?
                           bus.premio_in : PRM_NONE;
                state_d  = StEnd;
            end
            StEnd: begin
                fim_jogo = 1'b1;
                done     = 1'b1;
                games_d  = games_q + 8'd1;
                state_d  = StIdle;
            end
            StAbort: begin
                fim_jogo = 1'b1;
                done     = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            idx_q    <= 3'd0;
            ticket_q <= 20'd0;
            err_q    <= 1'b0;
            result_q <= PRM_NONE;
            games_q  <= 8'd0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            ticket_q <= ticket_d;
            err_q    <= err_d;
            result_q <= result_d;
            games_q  <= games_d;
        end
    end

    assign bus.ready    = ready;
    assign bus.num      = num;
    assign bus.insere   = insere;
    assign bus.fim      = fim;
    assign bus.fim_jogo = fim_jogo;
    assign bus.done     = done;
    assign bus.err      = err_q;
    assign bus.result   = result_q;
    assign bus.games    = games_q;
endmodule

// File: tb/tb_lot_ticket_tx.sv
// Self-checking bench for lot_ticket_tx; follows LOT_TX_GAP_EN when defined.
module tb_lot_ticket_tx;
    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;

`ifdef LOT_TX_GAP_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 1;
`endif

    logic [1:0] m_result;
    logic [7:0] m_games;

    lot_ticket_tx_if bus ();

    lot_ticket_tx dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] obs_vec();
        return {bus.ready, bus.num, bus.insere, bus.fim, bus.fim_jogo, bus.done, bus.err};
    endfunction

    // Model: digit k shows at cycle 1+k*STEP; fim, capture, end follow the last digit.
    task automatic run_ticket(input logic [19:0] tk, input logic [1:0] prm, input int glitch);
        int         dig[5];
        bit         valid;
        int         last, ncyc, k, ins_cnt, done_cnt;
        logic       ready_e, ins_e, fim_e, end_e, err_e;
        logic [3:0] num_e;
        valid = 1;
        for (int i = 0; i < 5; i++) begin
            dig[i] = int'((tk >> (4 * (4 - i))) & 20'hF);
            if (dig[i] > 9) valid = 0;
        end
        last     = 1 + 4 * STEP;
        ncyc     = valid ? last + 4 : 2;
        ins_cnt  = 0;
        done_cnt = 0;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.ticket    = tk;
        bus.premio_in = prm;
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) begin
                bus.start  = 1'b0;
                bus.ticket = ~tk;
            end
            if (valid) begin
                ins_e   = (c <= last) && ((c - 1) % STEP == 0);
                k       = (c - 1) / STEP;
                num_e   = (c <= last) ? 4'(dig[k]) : 4'd0;
                fim_e   = (c == last + 1);
                end_e   = (c == last + 3);
                ready_e = (c >= last + 4);
                err_e   = 1'b0;
                if (c == last + 3) m_result = (prm == 2'b11) ? 2'b00 : prm;
                if (c == last + 4) m_games = m_games + 8'd1;
            end else begin
                ins_e   = 1'b0;
                num_e   = 4'd0;
                fim_e   = 1'b0;
                end_e   = (c == 1);
                ready_e = (c == 2);
                err_e   = 1'b1;
            end
            ins_cnt  += int'(bus.insere);
            done_cnt += int'(bus.done);
            check($sformatf("cycle T+%0d ticket=%05h", c, tk), 32'(obs_vec()),
                  32'({ready_e, num_e, ins_e, fim_e, end_e, end_e, err_e}));
            check($sformatf("result/games T+%0d", c), 32'({bus.result, bus.games}),
                  32'({m_result, m_games}));
            if (glitch > 0) begin
                bus.start = (c + 1 == glitch);
                if (c + 1 == glitch) bus.ticket = 20'($urandom);
            end
        end
        bus.start = 1'b0;
        check($sformatf("insere count %05h", tk), 32'(ins_cnt), valid ? 32'd5 : 32'd0);
        check($sformatf("done count %05h", tk), 32'(done_cnt), 32'd1);
    endtask

    function automatic logic [19:0] rand_ticket(input bit allow_bad);
        logic [19:0] t;
        t = 20'd0;
        for (int i = 0; i < 5; i++) t = (t << 4) | 20'($urandom_range(9, 0));
        if (allow_bad && $urandom_range(3, 0) == 0) begin
            t[4 * $urandom_range(4, 0) +: 4] = 4'($urandom_range(15, 10));
        end
        return t;
    endfunction

    initial begin
        logic [7:0] g0;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.ticket    = 20'd0;
        bus.premio_in = 2'b00;
        m_result      = 2'b00;
        m_games       = 8'd0;
        repeat (3) @(negedge clk);
        check("reset outputs", 32'(obs_vec()), 32'({1'b1, 9'd0}));
        check("reset result/games", 32'({bus.result, bus.games}), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle after release", 32'(obs_vec()), 32'({1'b1, 9'd0}));

        run_ticket(20'h47019, 2'b01, 0);
        check("first ticket result", 32'(bus.result), 32'd1);
        check("first ticket games", 32'(bus.games), 32'd1);
        run_ticket(20'h4A019, 2'b10, 0);
        check("abort keeps games", 32'(bus.games), 32'd1);
        run_ticket(20'h12345, 2'b10, 0);
        check("prize 2 result", 32'(bus.result), 32'd2);
        run_ticket(20'h86420, 2'b11, 0);
        check("code 11 stored as none", 32'(bus.result), 32'd0);
        run_ticket(20'h24680, 2'b01, 3);

        for (int n = 0; n < 30; n++) begin
            run_ticket(rand_ticket(1'b1), 2'($urandom_range(3, 0)), 0);
        end

        // Reset while the third digit is on the bus.
        @(negedge clk);
        bus.start     = 1'b1;
        bus.ticket    = 20'h13579;
        bus.premio_in = 2'b01;
        for (int c = 1; c <= 1 + 2 * STEP; c++) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
        end
        check("third digit before reset", 32'({bus.insere, bus.num}), 32'({1'b1, 4'd5}));
        #2;
        reset = 1'b1;
        #1;
        m_result = 2'b00;
        m_games  = 8'd0;
        check("mid-ticket reset outputs", 32'(obs_vec()), 32'({1'b1, 9'd0}));
        check("mid-ticket reset result/games", 32'({bus.result, bus.games}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("quiet after reset %0d", c), 32'(obs_vec()), 32'({1'b1, 9'd0}));
        end

        g0 = m_games;
        for (int n = 0; n < 256; n++) begin
            run_ticket(rand_ticket(1'b0), 2'($urandom_range(3, 0)), 0);
        end
        check("games wrap after 256", 32'(bus.games), 32'(g0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
